ula_sequencer: RTL and testbench
================================

Name: ula_sequencer

Overview:
- Multi-cycle controller that owns the 8-bit ULA (the ALU).
- Accepts operation requests over a valid/ready channel and drives the ULA operand and opcode inputs.
- Keeps an 8-bit accumulator, latches the ULA result and the six ULA flags, and returns them over a valid/ready response channel.
- Also sequences a shift-add 8x8 multiply (low 8 bits) using only the ULA's 2*A and A+B operations.

Parameters:
- None. Widths are fixed: 8-bit data, 9-bit ULA result, 3-bit ULA opcode.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_cmd  in  4  command code.
- req_data  in  8  operand B.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  8  accumulator value after the command.
- rsp_flags  out  6  {igual, menor, maior, carry, negativo, zero}.
- rsp_err  out  1  reserved command was received.
- acc  out  8  live accumulator.
- busy  out  1  state is not IDLE.
- ula_a  out  8  ULA operand A.
- ula_b  out  8  ULA operand B.
- ula_cod  out  3  ULA opcode.
- ula_c  in  9  ULA result.
- ula_zero, ula_neg, ula_carry, ula_maior, ula_menor, ula_igual  in  1 each  ULA flags.

Behaviour:
- Reset (asynchronous): state=IDLE; acc, rsp_data, rsp_flags, rsp_err, operand/product registers and bit counter = 0; rsp_valid=0.
- Reset mid-operation aborts the command with no response.
- Opcode at reset is 3'b110; ula_a/ula_b are 0.
- req_ready = (state==IDLE). A request transfers on req_valid && req_ready, and cmd/data are registered on that edge.
- Commands:
  - 0-7: ALU op, ula_cod = cmd[2:0].
  - 8: LOAD, cod 111.
  - 9: CMP, cod 001; acc is not written.
  - 10: MUL.
  - 11-15: reserved.
- States: IDLE, EXEC, MUL_SHIFT, MUL_ADD, RESP.
- IDLE -> EXEC on acceptance for cmd 0-9.
- IDLE -> MUL_SHIFT for cmd 10, after loading:
  - ma = acc, mb = req_data, p = 0, cnt = 7, sticky = 0.
- IDLE -> RESP for cmd 11-15, with:
  - rsp_err = 1, rsp_flags = 0, rsp_data = acc.
  - acc is unchanged and the ULA is not used.
- EXEC (1 cycle):
  - Drive ula_a = acc, ula_b = registered data, ula_cod per command.
  - At cycle end: acc = ula_c[7:0] (except CMP), rsp_flags = ULA flags, rsp_err = 0, rsp_data = new acc. Then -> RESP.
- MUL_SHIFT:
  - Drive ula_a = p, cod = 101.
  - At cycle end: p = ula_c[7:0]; sticky |= ula_c[8].
  - If mb[cnt]=1 -> MUL_ADD.
  - Else if cnt=0 -> finish.
  - Else cnt-- and stay in MUL_SHIFT.
- MUL_ADD:
  - Drive ula_a = p, ula_b = ma, cod = 000.
  - At cycle end: p = ula_c[7:0]; sticky |= ula_c[8].
  - If cnt=0 -> finish, else cnt-- and -> MUL_SHIFT.
- MUL finish:
  - acc = rsp_data = p.
  - rsp_flags: zero = (p==0), carry = sticky, others 0.
  - Then -> RESP.
  - MUL execution takes 8 + popcount(mb) cycles.
- RESP:
  - rsp_valid = 1; rsp_data, rsp_flags and rsp_err are held stable until rsp_ready.
  - On rsp_valid && rsp_ready -> IDLE.
  - No new request is accepted in the same cycle (req_ready only rises in IDLE).
- Latency for cmd 0-9 and reserved commands:
  - Acceptance edge is cycle 0.
  - rsp_valid = 1 from cycle 2 for cmd 0-9 (EXEC is cycle 1), and from cycle 1 for reserved commands.
  - Throughput for cmd 0-9 is at most one command every 3 cycles.
- Outside EXEC/MUL states: ula_cod = 110, ula_a = acc, ula_b = 0.
- acc wraps modulo 256. The overflow indication is the carry flag only.

Test Plan:
- LOAD 200, then cmd 0 (ADD) with data 100:
  - rsp_data = 44 (0x2C), rsp_flags = 6'b001110, rsp_err = 0.
  - rsp_valid rises 2 cycles after acceptance.
- LOAD 5, then cmd 1 (SUB) with data 10 -> rsp_data = 0xFB, rsp_flags = 6'b010110.
- LOAD 7, then CMP (cmd 9) with data 7 -> rsp_flags = 6'b100001, acc stays 7.
- MUL cases:
  - LOAD 5, MUL 3 -> rsp_data = 15, carry = 0; exactly 10 execution cycles (8 shifts + 2 adds).
  - LOAD 20, MUL 20 -> rsp_data = 144, carry = 1.
  - LOAD 0, MUL 9 -> rsp_data = 0, zero = 1.
- Reserved command and backpressure:
  - cmd 13 -> rsp_err = 1, flags 0, acc unchanged.
  - With rsp_ready held low 3 cycles, response fields stay stable, req_ready = 0 and busy = 1.
- Reset mid-MUL:
  - rst pulse asynchronously during MUL_SHIFT -> all outputs return to reset values immediately.
  - No response is issued and req_ready = 1 on the first clock after release.

Source files
------------

// File: rtl/ula_sequencer.sv
// Multi-cycle controller for the 8-bit ULA: accumulator ops, compare, and a
// shift-add 8x8 multiply (low byte), with valid/ready request and response channels.
module ula_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_cmd,
  input  logic [7:0] req_data,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic [5:0] rsp_flags,
  output logic       rsp_err,
  output logic [7:0] acc,
  output logic       busy,
  output logic [7:0] ula_a,
  output logic [7:0] ula_b,
  output logic [2:0] ula_cod,
  input  logic [8:0] ula_c,
  input  logic       ula_zero,
  input  logic       ula_neg,
  input  logic       ula_carry,
  input  logic       ula_maior,
  input  logic       ula_menor,
  input  logic       ula_igual
);

  typedef enum logic [2:0] {IDLE, EXEC, MUL_SHIFT, MUL_ADD, RESP} state_t;

  localparam logic [2:0] COD_ADD  = 3'b000;
  localparam logic [2:0] COD_SUB  = 3'b001;
  localparam logic [2:0] COD_DBL  = 3'b101;
  localparam logic [2:0] COD_NOP  = 3'b110;
  localparam logic [2:0] COD_LOAD = 3'b111;

  localparam logic [3:0] CMD_LOAD = 4'd8;
  localparam logic [3:0] CMD_CMP  = 4'd9;
  localparam logic [3:0] CMD_MUL  = 4'd10;

  state_t     state;
  logic [3:0] cmd_r;
  logic [7:0] data_r;
  logic [7:0] ma, mb, p;
  logic [2:0] cnt;
  logic       sticky;

  logic [5:0] ula_flags;
  logic [7:0] p_nxt;
  logic       sticky_nxt;

  assign ula_flags  = {ula_igual, ula_menor, ula_maior, ula_carry, ula_neg, ula_zero};
  assign p_nxt      = ula_c[7:0];
  assign sticky_nxt = sticky | ula_c[8];

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

  // ULA drive is decoded from the registered state; idle drive keeps acc on A.
  always_comb begin
    ula_a   = acc;
    ula_b   = 8'd0;
    ula_cod = COD_NOP;
    case (state)
      EXEC: begin
        ula_b = data_r;
        if (cmd_r == CMD_LOAD)     ula_cod = COD_LOAD;
        else if (cmd_r == CMD_CMP) ula_cod = COD_SUB;
        else                       ula_cod = cmd_r[2:0];
      end
      MUL_SHIFT: begin
        ula_a   = p;
        ula_cod = COD_DBL;
      end
      MUL_ADD: begin
        ula_a   = p;
        ula_b   = ma;
        ula_cod = COD_ADD;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cmd_r     <= 4'd0;
      data_r    <= 8'd0;
      acc       <= 8'd0;
      rsp_data  <= 8'd0;
      rsp_flags <= 6'd0;
      rsp_err   <= 1'b0;
      ma        <= 8'd0;
      mb        <= 8'd0;
      p         <= 8'd0;
      cnt       <= 3'd0;
      sticky    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            cmd_r  <= req_cmd;
            data_r <= req_data;
            if (req_cmd <= CMD_CMP) begin
              state <= EXEC;
            end else if (req_cmd == CMD_MUL) begin
              ma     <= acc;
              mb     <= req_data;
              p      <= 8'd0;
              cnt    <= 3'd7;
              sticky <= 1'b0;
              state  <= MUL_SHIFT;
            end else begin
              rsp_err   <= 1'b1;
              rsp_flags <= 6'd0;
              rsp_data  <= acc;
              state     <= RESP;
            end
          end
        end
        EXEC: begin
          if (cmd_r != CMD_CMP) begin
            acc      <= ula_c[7:0];
            rsp_data <= ula_c[7:0];
          end else begin
            rsp_data <= acc;
          end
          rsp_flags <= ula_flags;
          rsp_err   <= 1'b0;
          state     <= RESP;
        end
        MUL_SHIFT: begin
          p      <= p_nxt;
          sticky <= sticky_nxt;
          if (mb[cnt]) begin
            state <= MUL_ADD;
          end else if (cnt == 3'd0) begin
            acc       <= p_nxt;
            rsp_data  <= p_nxt;
            rsp_flags <= {3'b000, sticky_nxt, 1'b0, (p_nxt == 8'd0)};
            rsp_err   <= 1'b0;
            state     <= RESP;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        MUL_ADD: begin
          p      <= p_nxt;
          sticky <= sticky_nxt;
          if (cnt == 3'd0) begin
            acc       <= p_nxt;
            rsp_data  <= p_nxt;
            rsp_flags <= {3'b000, sticky_nxt, 1'b0, (p_nxt == 8'd0)};
            rsp_err   <= 1'b0;
            state     <= RESP;
          end else begin
            cnt   <= cnt - 3'd1;
            state <= MUL_SHIFT;
          end
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_sequencer.sv
// Directed bench for ula_sequencer with a behavioural ULA attached to its operand/flag ports.
module tb_ula_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [3:0] req_cmd = 4'd0;
  logic [7:0] req_data = 8'd0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic [5:0] rsp_flags;
  logic       rsp_err;
  logic [7:0] acc;
  logic       busy;
  logic [7:0] ula_a, ula_b;
  logic [2:0] ula_cod;
  logic [8:0] ula_c;
  logic       ula_zero, ula_neg, ula_carry, ula_maior, ula_menor, ula_igual;

  int passed = 0;
  int total  = 0;
  int lat;
  logic [7:0] got_data;
  logic [5:0] got_flags;
  logic       got_err;

  always #5 clk = ~clk;

  ula_sequencer dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_flags(rsp_flags), .rsp_err(rsp_err), .acc(acc), .busy(busy),
    .ula_a(ula_a), .ula_b(ula_b), .ula_cod(ula_cod), .ula_c(ula_c),
    .ula_zero(ula_zero), .ula_neg(ula_neg), .ula_carry(ula_carry),
    .ula_maior(ula_maior), .ula_menor(ula_menor), .ula_igual(ula_igual)
  );

  // Behavioural ULA: 9-bit result, sign/carry taken from bit 8.
  always_comb begin
    case (ula_cod)
      3'b000:  ula_c = {1'b0, ula_a} + {1'b0, ula_b};
      3'b001:  ula_c = {1'b0, ula_a} - {1'b0, ula_b};
      3'b010:  ula_c = {1'b0, ula_a & ula_b};
      3'b011:  ula_c = {1'b0, ula_a | ula_b};
      3'b100:  ula_c = {1'b0, ula_a ^ ula_b};
      3'b101:  ula_c = {ula_a, 1'b0};
      3'b111:  ula_c = {1'b0, ula_b};
      default: ula_c = {1'b0, ula_a};
    endcase
  end
  assign ula_zero  = (ula_c[7:0] == 8'd0);
  assign ula_neg   = ula_c[8];
  assign ula_carry = ula_c[8];
  assign ula_maior = (ula_a > ula_b);
  assign ula_menor = (ula_a < ula_b);
  assign ula_igual = (ula_a == ula_b);

  // Issue one command, measure cycles to rsp_valid, capture the response (not consumed).
  task automatic issue(input logic [3:0] cmd, input logic [7:0] data);
    @(negedge clk);
    req_cmd = cmd; req_data = data; req_valid = 1'b1;
    lat = 0;
    while (lat < 100) begin
      @(negedge clk);
      req_valid = 1'b0;
      lat++;
      if (rsp_valid) break;
    end
    total++;
    if (!rsp_valid) $display("FAIL rsp_timeout cmd=%0d: no rsp_valid after %0d cycles", cmd, lat);
    else passed++;
    got_data = rsp_data; got_flags = rsp_flags; got_err = rsp_err;
  endtask

  task automatic take();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic run(input logic [3:0] cmd, input logic [7:0] data);
    issue(cmd, data);
    take();
  endtask

  task automatic test_reset();
    total += 9;
    if (req_ready !== 1'b1)      $display("FAIL reset_req_ready got %b want 1", req_ready); else passed++;
    if (rsp_valid !== 1'b0)      $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); else passed++;
    if (busy !== 1'b0)           $display("FAIL reset_busy got %b want 0", busy); else passed++;
    if (acc !== 8'd0)            $display("FAIL reset_acc got %h want 00", acc); else passed++;
    if (ula_cod !== 3'b110)      $display("FAIL reset_cod got %b want 110", ula_cod); else passed++;
    if (ula_a !== 8'd0 || ula_b !== 8'd0) $display("FAIL reset_ops got %h/%h want 00/00", ula_a, ula_b); else passed++;
    if (rsp_data !== 8'd0)       $display("FAIL reset_rsp_data got %h want 00", rsp_data); else passed++;
    if (rsp_flags !== 6'd0)      $display("FAIL reset_rsp_flags got %b want 0", rsp_flags); else passed++;
    if (rsp_err !== 1'b0)        $display("FAIL reset_rsp_err got %b want 0", rsp_err); else passed++;
  endtask

  task automatic test_alu();
    run(4'd8, 8'd200);
    total++;
    if (acc !== 8'd200) $display("FAIL load_acc got %0d want 200", acc); else passed++;
    issue(4'd0, 8'd100);
    total += 4;
    if (got_data !== 8'h2C)       $display("FAIL add_data got %h want 2c", got_data); else passed++;
    if (got_flags !== 6'b001110)  $display("FAIL add_flags got %b want 001110", got_flags); else passed++;
    if (got_err !== 1'b0)         $display("FAIL add_err got %b want 0", got_err); else passed++;
    if (lat != 2)                 $display("FAIL add_latency got %0d want 2", lat); else passed++;
    take();
    run(4'd8, 8'd5);
    issue(4'd1, 8'd10);
    total += 2;
    if (got_data !== 8'hFB)       $display("FAIL sub_data got %h want fb", got_data); else passed++;
    if (got_flags !== 6'b010110)  $display("FAIL sub_flags got %b want 010110", got_flags); else passed++;
    take();
    run(4'd8, 8'hF0);
    issue(4'd4, 8'h3C);
    total++;
    if (got_data !== 8'hCC)       $display("FAIL xor_data got %h want cc", got_data); else passed++;
    take();
  endtask

  task automatic test_cmp();
    run(4'd8, 8'd7);
    issue(4'd9, 8'd7);
    total += 3;
    if (got_flags !== 6'b100001)  $display("FAIL cmp_flags got %b want 100001", got_flags); else passed++;
    if (got_data !== 8'd7)        $display("FAIL cmp_data got %0d want 7", got_data); else passed++;
    if (acc !== 8'd7)             $display("FAIL cmp_acc got %0d want 7", acc); else passed++;
    take();
  endtask

  task automatic test_mul();
    run(4'd8, 8'd5);
    issue(4'd10, 8'd3);
    total += 3;
    if (got_data !== 8'd15)       $display("FAIL mul5x3_data got %0d want 15", got_data); else passed++;
    if (got_flags !== 6'b000000)  $display("FAIL mul5x3_flags got %b want 000000", got_flags); else passed++;
    if (lat != 11)                $display("FAIL mul5x3_latency got %0d want 11", lat); else passed++;
    take();
    run(4'd8, 8'd20);
    issue(4'd10, 8'd20);
    total += 3;
    if (got_data !== 8'd144)      $display("FAIL mul20x20_data got %0d want 144", got_data); else passed++;
    if (got_flags !== 6'b000100)  $display("FAIL mul20x20_flags got %b want 000100", got_flags); else passed++;
    if (acc !== 8'd144)           $display("FAIL mul20x20_acc got %0d want 144", acc); else passed++;
    take();
    run(4'd8, 8'd0);
    issue(4'd10, 8'd9);
    total += 2;
    if (got_data !== 8'd0)        $display("FAIL mul0x9_data got %0d want 0", got_data); else passed++;
    if (got_flags !== 6'b000001)  $display("FAIL mul0x9_flags got %b want 000001", got_flags); else passed++;
    take();
  endtask

  task automatic test_reserved_backpressure();
    run(4'd8, 8'h5A);
    issue(4'd13, 8'hFF);
    total += 4;
    if (got_err !== 1'b1)         $display("FAIL rsv_err got %b want 1", got_err); else passed++;
    if (got_flags !== 6'd0)       $display("FAIL rsv_flags got %b want 0", got_flags); else passed++;
    if (got_data !== 8'h5A)       $display("FAIL rsv_data got %h want 5a", got_data); else passed++;
    if (lat != 1)                 $display("FAIL rsv_latency got %0d want 1", lat); else passed++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (rsp_valid !== 1'b1 || rsp_data !== 8'h5A || rsp_err !== 1'b1 || rsp_flags !== 6'd0 ||
          req_ready !== 1'b0 || busy !== 1'b1 || acc !== 8'h5A)
        $display("FAIL hold_%0d got v=%b d=%h e=%b f=%b rr=%b busy=%b acc=%h want 1 5a 1 0 0 1 5a",
                 i, rsp_valid, rsp_data, rsp_err, rsp_flags, req_ready, busy, acc);
      else passed++;
    end
    take();
    total++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0)
      $display("FAIL rsv_release got rr=%b v=%b want 1 0", req_ready, rsp_valid); else passed++;
  endtask

  task automatic test_back_to_back();
    // second command is offered while the first is still in flight
    @(negedge clk);
    req_cmd = 4'd8; req_data = 8'd10; req_valid = 1'b1;
    @(negedge clk);
    req_cmd = 4'd0; req_data = 8'd1;
    @(negedge clk);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    total++;
    if (acc !== 8'd10) $display("FAIL b2b_first_acc got %0d want 10", acc); else passed++;
    lat = 0;
    while (lat < 20 && !rsp_valid) begin
      @(negedge clk);
      lat++;
    end
    req_valid = 1'b0;
    total += 2;
    if (rsp_data !== 8'd11) $display("FAIL b2b_second_data got %0d want 11", rsp_data); else passed++;
    if (lat != 2)           $display("FAIL b2b_second_latency got %0d want 2", lat); else passed++;
    take();
  endtask

  task automatic test_reset_mid_mul();
    run(4'd8, 8'd3);
    @(negedge clk);
    req_cmd = 4'd10; req_data = 8'hFF; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b1) $display("FAIL mul_started got busy=%b want 1", busy); else passed++;
    #2 rst = 1'b1;
    #1;
    total += 2;
    if (acc !== 8'd0 || busy !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0)
      $display("FAIL async_reset got acc=%h busy=%b rr=%b v=%b want 00 0 1 0", acc, busy, req_ready, rsp_valid);
    else passed++;
    if (ula_cod !== 3'b110 || ula_a !== 8'd0 || rsp_data !== 8'd0)
      $display("FAIL async_reset_ula got cod=%b a=%h d=%h want 110 00 00", ula_cod, ula_a, rsp_data);
    else passed++;
    #1 rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) begin
        total++;
        if (req_ready !== 1'b1) $display("FAIL post_reset_ready got %b want 1", req_ready); else passed++;
      end
      if (rsp_valid !== 1'b0) begin
        total++;
        $display("FAIL post_reset_rsp got rsp_valid=1 at cycle %0d want 0", i);
        break;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_alu();
    test_cmp();
    test_mul();
    test_reserved_backpressure();
    test_back_to_back();
    test_reset_mid_mul();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
